// File: rtl/vram_video_pkg.sv
// Shared definitions for the VRAM video path: default 640x480@60 raster
// timing, total-period helper, the fixed 16-colour palette and the RGB type.
package vram_video_pkg;

  typedef logic [23:0] rgb_t;

  localparam int DEF_WIDTH  = 128;
  localparam int DEF_HEIGHT = 128;
  localparam int DEF_SCALE  = 3;

  localparam int DEF_H_ACT  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;

  localparam int DEF_V_ACT  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam logic DEF_SYNC_POL = 1'b0;

  localparam int DEF_H_TOTAL = DEF_H_ACT + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_ACT + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  function automatic int period_total(input int act, input int fp,
                                      input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  // CGA ordering: 0 black .. 15 white.
  localparam rgb_t PALETTE [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

endpackage

// File: rtl/vram_video_timing.sv
// Raster timing generator: horizontal/vertical counters, active window,
// sync pulses and the frame-start strobe, all in the stage-0 position.
// Ports:
//   i_clk, i_rst        pixel clock, synchronous active-high reset
//   o_active            counters inside the visible area
//   o_hs, o_vs          sync levels (SYNC_POL while asserted)
//   o_frame_start       first cycle of vertical sync
//   o_line_end          last cycle of every line (h wraps)
//   o_line_end_act      last cycle of a visible line
//   o_frame_end         last cycle of the frame (h and v wrap together)
module vram_video_timing
  import vram_video_pkg::*;
#(
  parameter int   H_ACT    = DEF_H_ACT,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACT    = DEF_V_ACT,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_active,
  output logic o_hs,
  output logic o_vs,
  output logic o_frame_start,
  output logic o_line_end,
  output logic o_line_end_act,
  output logic o_frame_end
);

  localparam int H_TOTAL = period_total(H_ACT, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = period_total(V_ACT, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap, v_wrap;
  logic          h_vis, v_vis;

  always_comb begin
    h_wrap  = (int'(h_cnt_q) == H_TOTAL - 1);
    v_wrap  = (int'(v_cnt_q) == V_TOTAL - 1);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_comb begin
    h_vis          = (int'(h_cnt_q) < H_ACT);
    v_vis          = (int'(v_cnt_q) < V_ACT);
    o_active       = h_vis && v_vis;
    o_hs           = ((int'(h_cnt_q) >= H_ACT + H_FP) &&
                      (int'(h_cnt_q) <  H_ACT + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
    o_vs           = ((int'(v_cnt_q) >= V_ACT + V_FP) &&
                      (int'(v_cnt_q) <  V_ACT + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
    o_frame_start  = (h_cnt_q == '0) && (int'(v_cnt_q) == V_ACT + V_FP);
    o_line_end     = h_wrap;
    o_line_end_act = h_wrap && v_vis;
    o_frame_end    = h_wrap && v_wrap;
  end

endmodule

// File: rtl/vram_scanout.sv
// Video-side VRAM reader: raster timing, image tracking with SCALE-times
// pixel replication, 1-cycle synchronous VRAM fetch of packed nibbles and
// palette expansion to 24-bit RGB. Two-stage pipe from counter position to
// outputs; all outputs share the same latency.
// Ports:
//   i_clk, i_rst   pixel clock, synchronous active-high reset
//   o_mev          VRAM video-port select (fetch this cycle)
//   o_adrv         VRAM byte address (2 pixels per byte, low nibble = even pixel)
//   i_qv           VRAM read data, valid one cycle after o_mev/o_adrv
//   o_hsync/o_vsync sync outputs, o_de active video, o_rgb {R,G,B}
//   o_frame        one-cycle pulse with the first cycle of vertical sync
module vram_scanout
  import vram_video_pkg::*;
#(
  parameter int   WIDTH     = DEF_WIDTH,
  parameter int   HEIGHT    = DEF_HEIGHT,
  parameter int   SCALE     = DEF_SCALE,
  parameter int   WORD_SIZE = (WIDTH * HEIGHT + 1) >> 1,
  parameter int   H_ACT     = DEF_H_ACT,
  parameter int   H_FP      = DEF_H_FP,
  parameter int   H_SYNC    = DEF_H_SYNC,
  parameter int   H_BP      = DEF_H_BP,
  parameter int   V_ACT     = DEF_V_ACT,
  parameter int   V_FP      = DEF_V_FP,
  parameter int   V_SYNC    = DEF_V_SYNC,
  parameter int   V_BP      = DEF_V_BP,
  parameter logic SYNC_POL  = DEF_SYNC_POL
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  output logic                         o_mev,
  output logic [$clog2(WORD_SIZE)-1:0] o_adrv,
  input  logic [7:0]                   i_qv,
  output logic                         o_hsync,
  output logic                         o_vsync,
  output logic                         o_de,
  output logic [23:0]                  o_rgb,
  output logic                         o_frame
);

  localparam int AW = $clog2(WORD_SIZE);
  // AW+1 bits hold every displayable pixel index (W*H-1); row_base may
  // overflow once img_y saturates at HEIGHT, but in_img masks that case.
  localparam int PW = AW + 1;
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int SW = $clog2(SCALE + 1);

  localparam logic [SW-1:0] SUB_LAST = SW'(SCALE - 1);
  localparam logic [PW-1:0] ROW_STEP = PW'(WIDTH);

  logic active, hs, vs, frame_start, line_end, line_end_act, frame_end;

  vram_video_timing #(
    .H_ACT   (H_ACT),
    .H_FP    (H_FP),
    .H_SYNC  (H_SYNC),
    .H_BP    (H_BP),
    .V_ACT   (V_ACT),
    .V_FP    (V_FP),
    .V_SYNC  (V_SYNC),
    .V_BP    (V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_timing (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .o_active      (active),
    .o_hs          (hs),
    .o_vs          (vs),
    .o_frame_start (frame_start),
    .o_line_end    (line_end),
    .o_line_end_act(line_end_act),
    .o_frame_end   (frame_end)
  );

  // Stage 0: image position tracking (no division).
  logic [SW-1:0] sub_x_q, sub_x_d, sub_y_q, sub_y_d;
  logic [XW-1:0] img_x_q, img_x_d;
  logic [YW-1:0] img_y_q, img_y_d;
  logic [PW-1:0] row_base_q, row_base_d;

  always_comb begin
    sub_x_d    = sub_x_q;
    img_x_d    = img_x_q;
    sub_y_d    = sub_y_q;
    img_y_d    = img_y_q;
    row_base_d = row_base_q;

    if (line_end) begin
      sub_x_d = '0;
      img_x_d = '0;
    end else if (sub_x_q == SUB_LAST) begin
      sub_x_d = '0;
      // Saturate past the image edge so the counter cannot wrap back in.
      if (int'(img_x_q) < WIDTH) img_x_d = img_x_q + XW'(1);
    end else begin
      sub_x_d = sub_x_q + SW'(1);
    end

    if (frame_end) begin
      sub_y_d    = '0;
      img_y_d    = '0;
      row_base_d = '0;
    end else if (line_end_act) begin
      if (sub_y_q == SUB_LAST) begin
        sub_y_d = '0;
        if (int'(img_y_q) < HEIGHT) begin
          img_y_d    = img_y_q + YW'(1);
          row_base_d = row_base_q + ROW_STEP;
        end
      end else begin
        sub_y_d = sub_y_q + SW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sub_x_q    <= '0;
      img_x_q    <= '0;
      sub_y_q    <= '0;
      img_y_q    <= '0;
      row_base_q <= '0;
    end else begin
      sub_x_q    <= sub_x_d;
      img_x_q    <= img_x_d;
      sub_y_q    <= sub_y_d;
      img_y_q    <= img_y_d;
      row_base_q <= row_base_d;
    end
  end

  logic [PW-1:0] pix;
  logic          in_img;

  always_comb begin
    pix    = row_base_q + PW'(img_x_q);
    in_img = active && (int'(img_x_q) < WIDTH) && (int'(img_y_q) < HEIGHT);
  end

  assign o_mev  = in_img && !i_rst;
  assign o_adrv = pix[AW:1];

  // Stage 1: timing and nibble select aligned with the VRAM read latency.
  logic in_img_s1_q, sel_s1_q, de_s1_q, hs_s1_q, vs_s1_q, frame_s1_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      in_img_s1_q <= 1'b0;
      sel_s1_q    <= 1'b0;
      de_s1_q     <= 1'b0;
      hs_s1_q     <= ~SYNC_POL;
      vs_s1_q     <= ~SYNC_POL;
      frame_s1_q  <= 1'b0;
    end else begin
      in_img_s1_q <= in_img;
      sel_s1_q    <= pix[0];
      de_s1_q     <= active;
      hs_s1_q     <= hs;
      vs_s1_q     <= vs;
      frame_s1_q  <= frame_start;
    end
  end

  // Stage 2: palette lookup and output registers.
  logic [3:0] nibble;
  rgb_t       rgb_d, rgb_q;
  logic       de_q, hs_q, vs_q, frame_q;

  always_comb begin
    nibble = sel_s1_q ? i_qv[7:4] : i_qv[3:0];
    rgb_d  = in_img_s1_q ? PALETTE[nibble] : 24'h0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rgb_q   <= 24'h0;
      de_q    <= 1'b0;
      hs_q    <= ~SYNC_POL;
      vs_q    <= ~SYNC_POL;
      frame_q <= 1'b0;
    end else begin
      rgb_q   <= rgb_d;
      de_q    <= de_s1_q;
      hs_q    <= hs_s1_q;
      vs_q    <= vs_s1_q;
      frame_q <= frame_s1_q;
    end
  end

  assign o_rgb   = rgb_q;
  assign o_de    = de_q;
  assign o_hsync = hs_q;
  assign o_vsync = vs_q;
  assign o_frame = frame_q;

endmodule

// File: tb/tb_vram_scanout.sv
// Bench for vram_scanout with a reduced raster so whole frames stay short.
// A position model predicts every cycle's outputs; predictions are queued
// and popped two cycles later against the DUT outputs.
module tb_vram_scanout;

  localparam int W   = 7;
  localparam int H   = 5;
  localparam int S   = 3;
  localparam int WS  = (W * H + 1) >> 1;
  localparam int AW  = $clog2(WS);
  localparam int HA  = 24, HF = 2, HSY = 3, HB = 3;
  localparam int VA  = 18, VF = 2, VSY = 2, VB = 2;
  localparam int HT  = HA + HF + HSY + HB;
  localparam int VT  = VA + VF + VSY + VB;
  localparam logic SP = 1'b0;

  localparam logic [23:0] PAL [16] = '{
    24'h000000, 24'h0000AA, 24'h00AA00, 24'h00AAAA,
    24'hAA0000, 24'hAA00AA, 24'hAA5500, 24'hAAAAAA,
    24'h555555, 24'h5555FF, 24'h55FF55, 24'h55FFFF,
    24'hFF5555, 24'hFF55FF, 24'hFFFF55, 24'hFFFFFF
  };

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    qv  = 8'h00;
  logic          mev, hsync, vsync, de, frame;
  logic [AW-1:0] adrv;
  logic [23:0]   rgb;

  vram_scanout #(
    .WIDTH(W), .HEIGHT(H), .SCALE(S),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .SYNC_POL(SP)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .o_mev  (mev),
    .o_adrv (adrv),
    .i_qv   (qv),
    .o_hsync(hsync),
    .o_vsync(vsync),
    .o_de   (de),
    .o_rgb  (rgb),
    .o_frame(frame)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [WS];
  always @(posedge clk) if (mev) qv <= rom[adrv];

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic        fr;
    logic [23:0] rgb;
  } outv_t;

  typedef struct {
    outv_t o;
    logic  img;
    int    p;
    int    h;
    int    v;
  } sb_t;

  sb_t sbq[$];
  int  mh, mv;
  int  vectors     = 0;
  int  miscompares = 0;
  int  frames_seen = 0;

  function automatic sb_t model(input int h, input int v);
    sb_t        e;
    int         x, y;
    logic       act;
    logic [7:0] b;
    act      = (h < HA) && (v < VA);
    x        = h / S;
    y        = v / S;
    e.h      = h;
    e.v      = v;
    e.img    = act && (x < W) && (y < H);
    e.p      = y * W + x;
    e.o.de   = act;
    e.o.hs   = (h >= HA + HF && h < HA + HF + HSY) ? SP : !SP;
    e.o.vs   = (v >= VA + VF && v < VA + VF + VSY) ? SP : !SP;
    e.o.fr   = (h == 0) && (v == VA + VF);
    e.o.rgb  = 24'h0;
    if (e.img) begin
      b       = rom[e.p / 2];
      e.o.rgb = PAL[(e.p % 2 == 1) ? b[7:4] : b[3:0]];
    end
    return e;
  endfunction

  function automatic sb_t reset_entry();
    sb_t e;
    e.o   = '{de: 1'b0, hs: !SP, vs: !SP, fr: 1'b0, rgb: 24'h0};
    e.img = 1'b0;
    e.p   = 0;
    e.h   = -1;
    e.v   = -1;
    return e;
  endfunction

  // Called at a falling edge: checks the fetch port for the current model
  // position, queues its prediction, and checks the entry from two cycles ago.
  task automatic tick();
    sb_t   e, f;
    outv_t got;
    e = model(mh, mv);
    vectors++;
    if (mev !== e.img) begin
      miscompares++;
      $display("FAIL mev @h=%0d v=%0d: got %b want %b", mh, mv, mev, e.img);
    end
    if (e.img) begin
      vectors++;
      if (adrv !== AW'(e.p / 2)) begin
        miscompares++;
        $display("FAIL adrv @h=%0d v=%0d: got %0d want %0d", mh, mv, adrv, e.p / 2);
      end
    end
    sbq.push_back(e);
    f   = sbq.pop_front();
    got = {de, hsync, vsync, frame, rgb};
    vectors++;
    if (got !== f.o) begin
      miscompares++;
      $display("FAIL outputs @h=%0d v=%0d: got de=%b hs=%b vs=%b fr=%b rgb=%h want de=%b hs=%b vs=%b fr=%b rgb=%h",
               f.h, f.v, got.de, got.hs, got.vs, got.fr, got.rgb,
               f.o.de, f.o.hs, f.o.vs, f.o.fr, f.o.rgb);
    end
    if (frame === 1'b1) frames_seen++;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    @(negedge clk);
  endtask

  task automatic run_to(input int h, input int v, input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(mh == h && mv == v) && n < limit);
    vectors++;
    if (!(mh == h && mv == v)) begin
      miscompares++;
      $display("FAIL run_to: reached h=%0d v=%0d want h=%0d v=%0d", mh, mv, h, v);
    end
  endtask

  task automatic restart_model();
    sbq.delete();
    sbq.push_back(reset_entry());
    sbq.push_back(reset_entry());
    mh = 0;
    mv = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({mev, de, hsync, vsync, frame, rgb} !== {1'b0, 1'b0, !SP, !SP, 1'b0, 24'h0}) begin
      miscompares++;
      $display("FAIL reset_values: got mev=%b de=%b hs=%b vs=%b fr=%b rgb=%h want 0 0 1 1 0 000000",
               mev, de, hsync, vsync, frame, rgb);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    restart_model();
  endtask

  task automatic test_first_line();
    int          de_rise, hs_first, hs_cnt;
    logic [23:0] want_rgb;
    logic [AW-1:0] want_adrv;
    de_rise  = -1;
    hs_first = -1;
    hs_cnt   = 0;
    for (int t = 0; t < HT; t++) begin
      if (t <= 6) begin
        want_adrv = (t == 6) ? AW'(1) : AW'(0);
        vectors++;
        if (adrv !== want_adrv || mev !== 1'b1) begin
          miscompares++;
          $display("FAIL first_adrv t=%0d: got adrv=%0d mev=%b want adrv=%0d mev=1",
                   t, adrv, mev, want_adrv);
        end
      end
      if (t >= 2 && t <= 7) begin
        want_rgb = (t <= 4) ? 24'hFFFFFF : 24'h0000AA;
        vectors++;
        if (rgb !== want_rgb) begin
          miscompares++;
          $display("FAIL first_pixels t=%0d: got %h want %h", t, rgb, want_rgb);
        end
      end
      if (de === 1'b1 && de_rise < 0) de_rise = t;
      if (hsync === 1'b0) begin
        if (hs_first < 0) hs_first = t;
        hs_cnt++;
      end
      tick();
    end
    vectors++;
    if (de_rise != 2) begin
      miscompares++;
      $display("FAIL de_rise: got cycle %0d want 2", de_rise);
    end
    vectors++;
    if (hs_first != HA + HF + 2 || hs_cnt != HSY) begin
      miscompares++;
      $display("FAIL hsync_pulse: got start %0d len %0d want start %0d len %0d",
               hs_first, hs_cnt, HA + HF + 2, HSY);
    end
  endtask

  task automatic test_rows();
    run_to(0, S - 1, VT * HT);
    vectors++;
    if (adrv !== AW'(0) || mev !== 1'b1) begin
      miscompares++;
      $display("FAIL row0_last_line: got adrv=%0d mev=%b want 0 1", adrv, mev);
    end
    run_to(0, S, VT * HT);
    vectors++;
    if (adrv !== AW'(W / 2) || mev !== 1'b1) begin
      miscompares++;
      $display("FAIL row1_start: got adrv=%0d mev=%b want %0d 1", adrv, mev, W / 2);
    end
  endtask

  task automatic test_outside_x();
    run_to(W * S, 4, VT * HT);
    vectors++;
    if (mev !== 1'b0) begin
      miscompares++;
      $display("FAIL outside_x_mev: got %b want 0", mev);
    end
    tick();
    tick();
    vectors++;
    if (de !== 1'b1 || rgb !== 24'h0) begin
      miscompares++;
      $display("FAIL outside_x_out: got de=%b rgb=%h want 1 000000", de, rgb);
    end
  endtask

  task automatic test_last_pixel();
    run_to((W - 1) * S, (H - 1) * S, VT * HT);
    vectors++;
    if (adrv !== AW'(WS - 1) || mev !== 1'b1) begin
      miscompares++;
      $display("FAIL last_adrv: got adrv=%0d mev=%b want %0d 1", adrv, mev, WS - 1);
    end
    run_to(W * S - 1, H * S - 1, VT * HT);
    tick();
    tick();
    vectors++;
    if (rgb !== 24'hAA0000) begin
      miscompares++;
      $display("FAIL last_pixel_rgb: got %h want aa0000", rgb);
    end
    tick();
    vectors++;
    if (de !== 1'b1 || rgb !== 24'h0) begin
      miscompares++;
      $display("FAIL past_last_pixel: got de=%b rgb=%h want 1 000000", de, rgb);
    end
  endtask

  task automatic test_outside_y();
    run_to(0, H * S, VT * HT);
    vectors++;
    if (mev !== 1'b0) begin
      miscompares++;
      $display("FAIL outside_y_mev: got %b want 0", mev);
    end
  endtask

  task automatic test_frame_pulse();
    int f0;
    f0 = frames_seen;
    run_to(0, 0, VT * HT + 4);
    vectors++;
    if (frames_seen - f0 != 1) begin
      miscompares++;
      $display("FAIL frame_count: got %0d pulses want 1", frames_seen - f0);
    end
  endtask

  task automatic test_mid_reset();
    run_to(10, 5, VT * HT + 4);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vectors++;
    if (mev !== 1'b0) begin
      miscompares++;
      $display("FAIL mev_in_reset: got %b want 0", mev);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({de, hsync, vsync, frame, rgb} !== {1'b0, !SP, !SP, 1'b0, 24'h0}) begin
      miscompares++;
      $display("FAIL mid_reset_values: got de=%b hs=%b vs=%b fr=%b rgb=%h want 0 1 1 0 000000",
               de, hsync, vsync, frame, rgb);
    end
    restart_model();
    test_frame_pulse();
  endtask

  task automatic test_back_to_back();
    test_frame_pulse();
    run_to(HT / 2, 1, VT * HT);
  endtask

  initial begin
    for (int i = 0; i < WS; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0]      = 8'h1F;
    rom[WS - 1] = 8'hC4;
    mh = 0;
    mv = 0;
    test_reset();
    test_first_line();
    test_rows();
    test_outside_x();
    test_last_pixel();
    test_outside_y();
    test_frame_pulse();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
